upc_loop_monitor_rtl: RTL and testbench
=======================================

# upc_loop_monitor_rtl

Synthesizable, passive performance monitor that watches an HLS-style block-level `ap_ctrl` handshake and one pipelined loop inside it. It tracks block transactions and busy time, loop invocations, iteration starts/ends, stalls and in-flight iterations. It sits beside the observed kernel in the simulation or debug top and never drives the kernel.

## Interface
- `STATE_W`, default 2: width of the observed FSM state encoding.
- `CNT_W`, default 32: width of every counter.

- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `finish`  in  1: end of observation; freezes all state.
- `ap_start`, `ap_ready`, `ap_done`, `ap_continue`  in  1 each: block handshake.
- `cur_state`  in  STATE_W: observed FSM current state.
- `iter_start_state`, `iter_end_state`, `quit_state`  in  STATE_W: reference states.
- `iter_start_block`, `iter_end_block`, `quit_block`  in  1 each: stage stall (subdone) flags.
- `iter_start_enable`, `iter_end_enable`, `quit_enable`  in  1 each: pipeline stage enables.
- `loop_start`, `loop_ready`, `loop_done`, `loop_continue`  in  1 each: loop handshake.
- `quit_at_end`  in  1: quit-detection mode select.
- `mod_state`  out  2: block status, encoded 0 IDLE, 1 BUSY, 2 DONE_WAIT.
- `mod_start_cnt`, `mod_done_cnt`, `mod_busy_cycles`  out  CNT_W each.
- `loop_inv_cnt`, `iter_start_cnt`, `iter_end_cnt`, `stall_cycles`, `in_flight`  out  CNT_W each.
- `ev_iter_start`, `ev_iter_end`, `ev_quit`  out  1 each: registered one-cycle event pulses.
- `loop_active`, `frozen`, `err_underflow`  out  1 each.

## Operation
- Raw events, combinational on inputs:
  - `is` = `cur_state==iter_start_state` & `iter_start_enable` & !`iter_start_block`.
  - `ie` = `cur_state==iter_end_state` & `iter_end_enable` & !`iter_end_block`.
  - `q`, when `quit_at_end`=1: `loop_done` & `loop_active`.
  - `q`, when `quit_at_end`=0: `loop_active` & `cur_state==quit_state` & !`quit_block` & previous-cycle `quit_enable`=1 & current `quit_enable`=0.
- Block FSM:
  - IDLE goes to BUSY on `ap_start`.
  - BUSY goes to DONE_WAIT on `ap_done` & !`ap_continue`.
  - BUSY goes to IDLE on `ap_done` & `ap_continue`, or stays BUSY if `ap_start` is also high.
  - DONE_WAIT goes to IDLE on `ap_continue`.
- Block counters:
  - `mod_start_cnt` increments on `ap_start` & `ap_ready`.
  - `mod_done_cnt` increments on `ap_done` & `ap_continue`.
  - `mod_busy_cycles` increments on every cycle `mod_state`≠IDLE.
- Loop tracking:
  - `loop_active` sets on `loop_start` while inactive; `loop_inv_cnt` increments at the same time.
  - `loop_active` clears on `loop_done` & `loop_continue`, or on `q`, whichever comes first.
  - `iter_start_cnt` increments on `is`; `iter_end_cnt` increments on `ie`.
  - `stall_cycles` increments when `loop_active` & `cur_state==iter_start_state` & `iter_start_enable` & `iter_start_block`.
- `in_flight` (signed CNT_W): +1 on `is`, −1 on `ie`, unchanged when both fire in the same cycle.
- `ie` while `in_flight`=0 and no simultaneous `is`: `in_flight` stays 0 and `err_underflow` sets; it is sticky until reset.
- All counters saturate at all-ones, no wrap.
- `finish`=1 sets `frozen`, which is sticky until reset. While `frozen` is set, every counter, state and flag holds and event pulses are 0.

## Timing
- Every output is registered.
- Counters, `mod_state`, `loop_active` and event pulses reflect a cycle-N input on the cycle-N+1 output, one cycle of latency.
- Reset forces every output and the previous-`quit_enable` register to 0; `mod_state` resets to IDLE.
- Reset mid-transaction discards all history.
- `reset` takes priority over `finish`.
- `finish` asserted in the same cycle as an event: that event is not counted.
- `loop_start` and `q` in the same cycle while inactive: the invocation counts and the loop stays inactive.

## Structure
- Package `upc_mon_pkg`: `mod_state_t` enum (IDLE, BUSY, DONE_WAIT) and a saturating-increment helper function.
- Sub-module `sat_counter` (CNT_W, enable, freeze), instantiated once per counter.
- `in_flight` stays inline because it counts up and down.

## Test plan
- Reset then idle: all outputs 0, `mod_state`=IDLE.
- `ap_start` held 1 cycle with `ap_ready`, then `ap_done` & `ap_continue` 5 cycles later: `mod_start_cnt`=1, `mod_done_cnt`=1, `mod_busy_cycles`=5, `mod_state` returns to IDLE.
- Loop of 8 iterations, II=1, 1-cycle skew between `is` and `ie`: `iter_start_cnt`=8, `iter_end_cnt`=8, `in_flight` peaks at 1 and ends at 0, `loop_inv_cnt`=1.
- Stall `iter_start_block` for 3 cycles mid-loop: `stall_cycles`=3 and iteration counts unchanged by the stall.
- `ie` with nothing in flight: `err_underflow`=1, `in_flight`=0; assert `finish` then pulse `is`: counts unchanged, `frozen`=1.
- `quit_at_end`=0 and `quit_enable` falling at `quit_state`: `ev_quit` pulses once and `loop_active` drops the next cycle.

Source files
------------

// File: rtl/upc_mon_pkg.sv
// Shared types and helpers for the ap_ctrl / pipelined-loop performance monitor.
//   mod_state_t : block-level handshake status (IDLE, BUSY, DONE_WAIT)
//   sat_inc     : width-generic saturating increment (holds at all-ones)
package upc_mon_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StBusy     = 2'd1,
        StDoneWait = 2'd2
    } mod_state_t;

    // Widest counter the helper supports; callers zero-extend into it.
    localparam int unsigned MaxCntW = 64;

    // Increment value unless it already equals the all-ones pattern of `width` bits.
    function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] value,
                                                   input int unsigned        width);
        logic [MaxCntW-1:0] max_val;
        max_val = {MaxCntW{1'b1}} >> (MaxCntW - width);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high; clears the count
//   enable : count one event this cycle
//   freeze : suppress counting (monitor frozen or finishing)
//   count  : registered count, holds at all-ones
module sat_counter
    import upc_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (enable && !freeze) begin
            count_d = CNT_W'(sat_inc(MaxCntW'(count_q), CNT_W));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/upc_loop_monitor_rtl.sv
// Passive performance monitor for an HLS ap_ctrl block and one pipelined loop inside it.
// Never drives the observed kernel; every output is registered.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   finish                  : stop observing; sets sticky `frozen`, all state then holds
//   ap_start/ready/done/continue : block handshake
//   cur_state, *_state      : observed FSM state and reference states for the loop stages
//   *_block, *_enable       : stage stall flags and pipeline stage enables
//   loop_start/ready/done/continue, quit_at_end : loop handshake, quit-detection mode
//   mod_state               : 0 IDLE, 1 BUSY, 2 DONE_WAIT
//   mod_*_cnt, mod_busy_cycles, loop_inv_cnt, iter_*_cnt, stall_cycles : saturating counters
//   in_flight               : iterations started but not ended (never below 0)
//   ev_iter_start/end, ev_quit : one-cycle event pulses
//   loop_active, frozen, err_underflow : status flags
module upc_loop_monitor_rtl
    import upc_mon_pkg::*;
#(
    parameter int unsigned STATE_W = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    output logic [1:0]         mod_state,
    output logic [CNT_W-1:0]   mod_start_cnt,
    output logic [CNT_W-1:0]   mod_done_cnt,
    output logic [CNT_W-1:0]   mod_busy_cycles,
    output logic [CNT_W-1:0]   loop_inv_cnt,
    output logic [CNT_W-1:0]   iter_start_cnt,
    output logic [CNT_W-1:0]   iter_end_cnt,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   in_flight,
    output logic               ev_iter_start,
    output logic               ev_iter_end,
    output logic               ev_quit,
    output logic               loop_active,
    output logic               frozen,
    output logic               err_underflow
);

    mod_state_t       mod_state_q, mod_state_d;
    logic             loop_active_q, loop_active_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic             err_q, err_d;
    logic             frozen_q;
    logic             quit_en_prev_q;
    logic             ev_is_q, ev_ie_q, ev_q_q;

    logic run;
    logic is_evt, ie_evt, q_evt;
    logic stall_evt, busy_evt, start_evt, done_evt, inv_evt;

    // loop_ready carries no information the monitor needs.
    logic unused_loop_ready;
    assign unused_loop_ready = loop_ready;

    // A finish in the current cycle already blocks that cycle's events.
    assign run = !frozen_q && !finish;

    // Raw events
    always_comb begin
        is_evt = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
        ie_evt = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
        if (quit_at_end) begin
            q_evt = loop_done && loop_active_q;
        end else begin
            // Quit stage enable falling while sitting in the quit state.
            q_evt = loop_active_q && (cur_state == quit_state) && !quit_block &&
                    quit_en_prev_q && !quit_enable;
        end
        stall_evt = loop_active_q && (cur_state == iter_start_state) &&
                    iter_start_enable && iter_start_block;
        busy_evt  = (mod_state_q != StIdle);
        start_evt = ap_start && ap_ready;
        done_evt  = ap_done && ap_continue;
        inv_evt   = loop_start && !loop_active_q;
    end

    // Block FSM next state
    always_comb begin
        mod_state_d = mod_state_q;
        case (mod_state_q)
            StIdle: begin
                if (ap_start) mod_state_d = StBusy;
            end
            StBusy: begin
                if (ap_done) begin
                    if (!ap_continue) mod_state_d = StDoneWait;
                    else if (!ap_start) mod_state_d = StIdle;
                end
            end
            StDoneWait: begin
                if (ap_continue) mod_state_d = StIdle;
            end
            default: mod_state_d = StIdle;
        endcase
    end

    // Loop activity; a start coinciding with a quit leaves the loop inactive.
    always_comb begin
        if (loop_active_q) begin
            loop_active_d = !((loop_done && loop_continue) || q_evt);
        end else begin
            loop_active_d = loop_start && !q_evt;
        end
    end

    // In-flight tracking; an unmatched end is clamped at zero and flagged.
    always_comb begin
        in_flight_d = in_flight_q;
        err_d       = err_q;
        if (is_evt && !ie_evt) begin
            in_flight_d = CNT_W'(sat_inc(MaxCntW'(in_flight_q), CNT_W));
        end else if (ie_evt && !is_evt) begin
            if (in_flight_q == '0) begin
                err_d = 1'b1;
            end else begin
                in_flight_d = in_flight_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mod_state_q    <= StIdle;
            loop_active_q  <= 1'b0;
            in_flight_q    <= '0;
            err_q          <= 1'b0;
            frozen_q       <= 1'b0;
            quit_en_prev_q <= 1'b0;
            ev_is_q        <= 1'b0;
            ev_ie_q        <= 1'b0;
            ev_q_q         <= 1'b0;
        end else begin
            frozen_q <= frozen_q || finish;
            if (run) begin
                mod_state_q    <= mod_state_d;
                loop_active_q  <= loop_active_d;
                in_flight_q    <= in_flight_d;
                err_q          <= err_d;
                quit_en_prev_q <= quit_enable;
                ev_is_q        <= is_evt;
                ev_ie_q        <= ie_evt;
                ev_q_q         <= q_evt;
            end else begin
                ev_is_q <= 1'b0;
                ev_ie_q <= 1'b0;
                ev_q_q  <= 1'b0;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_mod_start_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (start_evt),
        .freeze (!run),
        .count  (mod_start_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mod_done_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (done_evt),
        .freeze (!run),
        .count  (mod_done_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mod_busy_cycles (
        .clock  (clock),
        .reset  (reset),
        .enable (busy_evt),
        .freeze (!run),
        .count  (mod_busy_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_loop_inv_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (inv_evt),
        .freeze (!run),
        .count  (loop_inv_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_iter_start_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (is_evt),
        .freeze (!run),
        .count  (iter_start_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_iter_end_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (ie_evt),
        .freeze (!run),
        .count  (iter_end_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cycles (
        .clock  (clock),
        .reset  (reset),
        .enable (stall_evt),
        .freeze (!run),
        .count  (stall_cycles)
    );

    assign mod_state     = mod_state_q;
    assign in_flight     = in_flight_q;
    assign ev_iter_start = ev_is_q;
    assign ev_iter_end   = ev_ie_q;
    assign ev_quit       = ev_q_q;
    assign loop_active   = loop_active_q;
    assign frozen        = frozen_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_upc_loop_monitor_rtl.sv
module tb_upc_loop_monitor_rtl;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int CntMax = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic finish, ap_start, ap_ready, ap_done, ap_continue;
    logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic iter_start_block, iter_end_block, quit_block;
    logic iter_start_enable, iter_end_enable, quit_enable;
    logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
    logic [1:0] mod_state;
    logic [CNT_W-1:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles, loop_inv_cnt;
    logic [CNT_W-1:0] iter_start_cnt, iter_end_cnt, stall_cycles, in_flight;
    logic ev_iter_start, ev_iter_end, ev_quit, loop_active, frozen, err_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_state, m_start, m_done, m_busy, m_inv, m_is, m_ie, m_stall, m_infl;
    bit m_err, m_active, m_frozen, m_evis, m_evie, m_evq, m_qprev;

    upc_loop_monitor_rtl #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .finish            (finish),
        .ap_start          (ap_start),
        .ap_ready          (ap_ready),
        .ap_done           (ap_done),
        .ap_continue       (ap_continue),
        .cur_state         (cur_state),
        .iter_start_state  (iter_start_state),
        .iter_end_state    (iter_end_state),
        .quit_state        (quit_state),
        .iter_start_block  (iter_start_block),
        .iter_end_block    (iter_end_block),
        .quit_block        (quit_block),
        .iter_start_enable (iter_start_enable),
        .iter_end_enable   (iter_end_enable),
        .quit_enable       (quit_enable),
        .loop_start        (loop_start),
        .loop_ready        (loop_ready),
        .loop_done         (loop_done),
        .loop_continue     (loop_continue),
        .quit_at_end       (quit_at_end),
        .mod_state         (mod_state),
        .mod_start_cnt     (mod_start_cnt),
        .mod_done_cnt      (mod_done_cnt),
        .mod_busy_cycles   (mod_busy_cycles),
        .loop_inv_cnt      (loop_inv_cnt),
        .iter_start_cnt    (iter_start_cnt),
        .iter_end_cnt      (iter_end_cnt),
        .stall_cycles      (stall_cycles),
        .in_flight         (in_flight),
        .ev_iter_start     (ev_iter_start),
        .ev_iter_end       (ev_iter_end),
        .ev_quit           (ev_quit),
        .loop_active       (loop_active),
        .frozen            (frozen),
        .err_underflow     (err_underflow)
    );

    always #5 clock = ~clock;

    function automatic int sat(input int v);
        return (v >= CntMax) ? v : v + 1;
    endfunction

    // Applies the monitor's rules to the inputs presented this cycle.
    task automatic model_step();
        bit is_e, ie_e, q_e;
        if (reset) begin
            m_state = 0; m_start = 0; m_done = 0; m_busy = 0; m_inv = 0;
            m_is = 0; m_ie = 0; m_stall = 0; m_infl = 0;
            m_err = 0; m_active = 0; m_frozen = 0; m_evis = 0; m_evie = 0; m_evq = 0;
            m_qprev = 0;
            return;
        end
        if (m_frozen || finish) begin
            m_frozen = 1;
            m_evis = 0; m_evie = 0; m_evq = 0;
            return;
        end
        is_e = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
        ie_e = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
        q_e  = quit_at_end ? (loop_done && m_active)
                           : (m_active && cur_state == quit_state && !quit_block &&
                              m_qprev && !quit_enable);
        if (ap_start && ap_ready) m_start = sat(m_start);
        if (ap_done && ap_continue) m_done = sat(m_done);
        if (m_state != 0) m_busy = sat(m_busy);
        if (m_active && cur_state == iter_start_state && iter_start_enable && iter_start_block)
            m_stall = sat(m_stall);
        if (is_e) m_is = sat(m_is);
        if (ie_e) m_ie = sat(m_ie);
        if (is_e && !ie_e) m_infl = sat(m_infl);
        else if (ie_e && !is_e) begin
            if (m_infl == 0) m_err = 1;
            else m_infl = m_infl - 1;
        end
        if (m_state == 0) begin
            if (ap_start) m_state = 1;
        end else if (m_state == 1) begin
            if (ap_done) m_state = !ap_continue ? 2 : (ap_start ? 1 : 0);
        end else begin
            if (ap_continue) m_state = 0;
        end
        if (!m_active) begin
            if (loop_start) begin
                m_inv = sat(m_inv);
                m_active = !q_e;
            end
        end else if ((loop_done && loop_continue) || q_e) begin
            m_active = 0;
        end
        m_evis = is_e; m_evie = ie_e; m_evq = q_e;
        m_qprev = quit_enable;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
        cur_state = 0; iter_start_state = 0; iter_end_state = 0; quit_state = 0;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic randomize_inputs();
        ap_start = ($urandom_range(0, 3) == 0);
        ap_ready = $urandom_range(0, 1);
        ap_done = ($urandom_range(0, 3) == 0);
        ap_continue = $urandom_range(0, 1);
        cur_state = STATE_W'($urandom_range(0, 3));
        iter_start_block = ($urandom_range(0, 3) == 0);
        iter_end_block = ($urandom_range(0, 3) == 0);
        quit_block = ($urandom_range(0, 3) == 0);
        iter_start_enable = $urandom_range(0, 1);
        iter_end_enable = $urandom_range(0, 1);
        quit_enable = $urandom_range(0, 1);
        loop_start = ($urandom_range(0, 3) == 0);
        loop_ready = $urandom_range(0, 1);
        loop_done = ($urandom_range(0, 5) == 0);
        loop_continue = $urandom_range(0, 1);
        quit_at_end = $urandom_range(0, 1);
    endtask

    task automatic test_reset();
        clear_inputs();
        for (int i = 0; i < 20; i++) begin
            randomize_inputs();
            iter_start_state = 1; iter_end_state = 2;
            cycle();
        end
        clear_inputs();
        do_reset();
        checks++;
        if ({mod_start_cnt, mod_done_cnt, mod_busy_cycles, loop_inv_cnt, iter_start_cnt,
             iter_end_cnt, stall_cycles, in_flight} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h %h %h %h %h %h %h want all 0",
                     mod_start_cnt, mod_done_cnt, mod_busy_cycles, loop_inv_cnt,
                     iter_start_cnt, iter_end_cnt, stall_cycles, in_flight);
        end
        checks++;
        if ({ev_iter_start, ev_iter_end, ev_quit, loop_active, frozen, err_underflow} !== 6'b0)
        begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {ev_iter_start, ev_iter_end, ev_quit, loop_active, frozen, err_underflow});
        end
        cycle(); cycle();
        checks++;
        if (mod_state !== 2'd0 || mod_busy_cycles !== '0) begin
            errors++;
            $display("FAIL reset_idle: got state %0d busy %0d want 0 0", mod_state,
                     mod_busy_cycles);
        end
    endtask

    task automatic test_block_txn();
        clear_inputs();
        do_reset();
        ap_start = 1; ap_ready = 1;
        cycle();
        ap_start = 0; ap_ready = 0;
        checks++;
        if (mod_state !== 2'd1) begin
            errors++;
            $display("FAIL blk_busy: got state %0d want 1", mod_state);
        end
        for (int i = 0; i < 4; i++) cycle();
        ap_done = 1; ap_continue = 1;
        cycle();
        ap_done = 0; ap_continue = 0;
        checks++;
        if (mod_start_cnt !== 8'd1 || mod_done_cnt !== 8'd1) begin
            errors++;
            $display("FAIL blk_counts: got start %0d done %0d want 1 1", mod_start_cnt,
                     mod_done_cnt);
        end
        checks++;
        if (mod_busy_cycles !== 8'd5 || mod_state !== 2'd0) begin
            errors++;
            $display("FAIL blk_busy_cycles: got busy %0d state %0d want 5 0",
                     mod_busy_cycles, mod_state);
        end
        // Done without continue parks in DONE_WAIT
        ap_start = 1; cycle(); ap_start = 0;
        ap_done = 1; cycle(); ap_done = 0;
        checks++;
        if (mod_state !== 2'd2 || mod_done_cnt !== 8'd1) begin
            errors++;
            $display("FAIL blk_done_wait: got state %0d done %0d want 2 1", mod_state,
                     mod_done_cnt);
        end
        ap_continue = 1; cycle(); ap_continue = 0;
        checks++;
        if (mod_state !== 2'd0 || mod_start_cnt !== 8'd1) begin
            errors++;
            $display("FAIL blk_continue: got state %0d start %0d want 0 1", mod_state,
                     mod_start_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        do_reset();
        ap_start = 1; ap_ready = 1; cycle();
        ap_done = 1; ap_continue = 1; cycle();
        checks++;
        if (mod_state !== 2'd1 || mod_done_cnt !== 8'd1 || mod_start_cnt !== 8'd2) begin
            errors++;
            $display("FAIL b2b_stay_busy: got state %0d done %0d start %0d want 1 1 2",
                     mod_state, mod_done_cnt, mod_start_cnt);
        end
        ap_start = 0; ap_ready = 0; cycle();
        ap_done = 0; ap_continue = 0;
        checks++;
        if (mod_state !== 2'd0 || mod_done_cnt !== 8'd2 || mod_busy_cycles !== 8'd2) begin
            errors++;
            $display("FAIL b2b_end: got state %0d done %0d busy %0d want 0 2 2",
                     mod_state, mod_done_cnt, mod_busy_cycles);
        end
    endtask

    task automatic test_loop();
        int peak = 0;
        int pulses = 0;
        clear_inputs();
        do_reset();
        iter_start_state = 1; iter_end_state = 1; cur_state = 1;
        loop_start = 1; cycle(); loop_start = 0;
        for (int k = 1; k <= 9; k++) begin
            iter_start_enable = (k <= 8);
            iter_end_enable = (k >= 2);
            cycle();
            if (int'(in_flight) > peak) peak = int'(in_flight);
            if (ev_iter_start) pulses++;
        end
        iter_start_enable = 0; iter_end_enable = 0;
        checks++;
        if (iter_start_cnt !== 8'd8 || iter_end_cnt !== 8'd8) begin
            errors++;
            $display("FAIL loop_iters: got start %0d end %0d want 8 8", iter_start_cnt,
                     iter_end_cnt);
        end
        checks++;
        if (peak != 1 || in_flight !== 8'd0) begin
            errors++;
            $display("FAIL loop_in_flight: got peak %0d final %0d want 1 0", peak, in_flight);
        end
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL loop_ev_pulses: got %0d want 8", pulses);
        end
        loop_done = 1; loop_continue = 1; cycle();
        loop_done = 0; loop_continue = 0;
        checks++;
        if (loop_inv_cnt !== 8'd1 || loop_active !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL loop_end: got inv %0d active %0b err %0b want 1 0 0",
                     loop_inv_cnt, loop_active, err_underflow);
        end
    endtask

    task automatic test_stall();
        clear_inputs();
        do_reset();
        iter_start_state = 2; cur_state = 2; iter_end_state = 0;
        loop_start = 1; cycle(); loop_start = 0;
        for (int k = 0; k < 11; k++) begin
            iter_start_enable = 1;
            iter_start_block = (k >= 4 && k <= 6);
            cycle();
            if (k == 6) begin
                checks++;
                if (iter_start_cnt !== 8'd4 || stall_cycles !== 8'd3) begin
                    errors++;
                    $display("FAIL stall_mid: got start %0d stall %0d want 4 3",
                             iter_start_cnt, stall_cycles);
                end
            end
        end
        iter_start_enable = 0; iter_start_block = 0;
        checks++;
        if (stall_cycles !== 8'd3 || iter_start_cnt !== 8'd8 || in_flight !== 8'd8) begin
            errors++;
            $display("FAIL stall_end: got stall %0d start %0d infl %0d want 3 8 8",
                     stall_cycles, iter_start_cnt, in_flight);
        end
    endtask

    task automatic test_underflow_freeze();
        clear_inputs();
        do_reset();
        iter_start_state = 2; iter_end_state = 2; cur_state = 2;
        iter_end_enable = 1; cycle(); iter_end_enable = 0;
        checks++;
        if (err_underflow !== 1'b1 || in_flight !== 8'd0 || iter_end_cnt !== 8'd1) begin
            errors++;
            $display("FAIL underflow: got err %0b infl %0d end %0d want 1 0 1",
                     err_underflow, in_flight, iter_end_cnt);
        end
        finish = 1; iter_start_enable = 1; cycle();
        checks++;
        if (frozen !== 1'b1 || iter_start_cnt !== 8'd0 || ev_iter_start !== 1'b0) begin
            errors++;
            $display("FAIL freeze_same_cycle: got frozen %0b start %0d ev %0b want 1 0 0",
                     frozen, iter_start_cnt, ev_iter_start);
        end
        finish = 0; cycle(); cycle();
        iter_start_enable = 0;
        checks++;
        if (iter_start_cnt !== 8'd0 || in_flight !== 8'd0 || frozen !== 1'b1 ||
            err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL freeze_hold: got start %0d infl %0d frozen %0b err %0b want 0 0 1 1",
                     iter_start_cnt, in_flight, frozen, err_underflow);
        end
        reset = 1; finish = 1; cycle(); reset = 0; finish = 0;
        checks++;
        if (frozen !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_finish: got frozen %0b err %0b want 0 0", frozen,
                     err_underflow);
        end
    endtask

    task automatic test_quit();
        int pulses = 0;
        clear_inputs();
        do_reset();
        quit_state = 3; cur_state = 3; iter_start_state = 0; iter_end_state = 0;
        loop_start = 1; cycle(); loop_start = 0;
        quit_enable = 1; cycle();
        checks++;
        if (loop_active !== 1'b1 || ev_quit !== 1'b0) begin
            errors++;
            $display("FAIL quit_pre: got active %0b ev %0b want 1 0", loop_active, ev_quit);
        end
        quit_enable = 0; cycle();
        if (ev_quit) pulses++;
        checks++;
        if (loop_active !== 1'b0 || ev_quit !== 1'b1) begin
            errors++;
            $display("FAIL quit_fire: got active %0b ev %0b want 0 1", loop_active, ev_quit);
        end
        cycle();
        if (ev_quit) pulses++;
        cycle();
        if (ev_quit) pulses++;
        checks++;
        if (pulses != 1 || loop_inv_cnt !== 8'd1) begin
            errors++;
            $display("FAIL quit_once: got pulses %0d inv %0d want 1 1", pulses, loop_inv_cnt);
        end
        // Quit-at-end mode: loop_done alone ends the invocation
        quit_at_end = 1;
        loop_start = 1; cycle(); loop_start = 0;
        loop_done = 1; cycle(); loop_done = 0;
        checks++;
        if (loop_active !== 1'b0 || ev_quit !== 1'b1 || loop_inv_cnt !== 8'd2) begin
            errors++;
            $display("FAIL quit_at_end: got active %0b ev %0b inv %0d want 0 1 2",
                     loop_active, ev_quit, loop_inv_cnt);
        end
    endtask

    task automatic test_random();
        clear_inputs();
        do_reset();
        iter_start_state = STATE_W'($urandom_range(0, 3));
        iter_end_state = STATE_W'($urandom_range(0, 3));
        quit_state = STATE_W'($urandom_range(0, 3));
        for (int c = 0; c < 700; c++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 149) == 0);
            finish = (c > 640) && ($urandom_range(0, 19) == 0);
            cycle();
            checks++;
            if (mod_state !== 2'(m_state) || mod_start_cnt !== CNT_W'(m_start) ||
                mod_done_cnt !== CNT_W'(m_done) || mod_busy_cycles !== CNT_W'(m_busy)) begin
                errors++;
                $display("FAIL rnd_block c=%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", c,
                         mod_state, mod_start_cnt, mod_done_cnt, mod_busy_cycles,
                         m_state, m_start, m_done, m_busy);
            end
            checks++;
            if (loop_inv_cnt !== CNT_W'(m_inv) || iter_start_cnt !== CNT_W'(m_is) ||
                iter_end_cnt !== CNT_W'(m_ie) || stall_cycles !== CNT_W'(m_stall) ||
                in_flight !== CNT_W'(m_infl)) begin
                errors++;
                $display("FAIL rnd_loop c=%0d: got %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d",
                         c, loop_inv_cnt, iter_start_cnt, iter_end_cnt, stall_cycles,
                         in_flight, m_inv, m_is, m_ie, m_stall, m_infl);
            end
            checks++;
            if ({ev_iter_start, ev_iter_end, ev_quit, loop_active, frozen, err_underflow} !==
                {m_evis, m_evie, m_evq, m_active, m_frozen, m_err}) begin
                errors++;
                $display("FAIL rnd_flags c=%0d: got %b want %b", c,
                         {ev_iter_start, ev_iter_end, ev_quit, loop_active, frozen,
                          err_underflow},
                         {m_evis, m_evie, m_evq, m_active, m_frozen, m_err});
            end
        end
        reset = 0; finish = 0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_block_txn();
        test_back_to_back();
        test_loop();
        test_stall();
        test_underflow_freeze();
        test_quit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
